// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, field positions, exception codes
// and the handler entry point.
package cp0_pkg;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam int IM_HI   = 15;
    localparam int IM_LO   = 10;
    localparam int EXL_BIT = 1;
    localparam int IE_BIT  = 0;
    localparam int BD_BIT  = 31;
    localparam int IP_HI   = 15;
    localparam int IP_LO   = 10;
    localparam int EXC_HI  = 6;
    localparam int EXC_LO  = 2;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] EXCEPTION_HANDLER_ADDR = 32'h0000_4180;
    localparam logic [31:0] PRID_DEFAULT           = 32'h0000_0810;

endpackage

// File: rtl/cp0.sv
// Coprocessor 0 in the M stage: takes exceptions/interrupts, records
// EPC/Cause/BD, and serves mfc0/mtc0/eret.
module cp0
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID = PRID_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic        ExcOccurIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        ExcHandle,
    output logic [31:0] EPC,
    output logic [31:0] DOut
);

    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  exc_code;
    logic [31:0] epc_q;

    logic        int_req;
    logic        exc_req;
    logic [31:0] victim;
    logic [31:0] sr_word;
    logic [31:0] cause_word;

    assign int_req   = ie & ~exl & (|(HWInt & im));
    assign exc_req   = ExcOccurIn & ~exl;
    assign ExcHandle = ~reset & (int_req | exc_req);

    // A delay-slot victim restarts at its branch so the branch re-executes.
    assign victim = (BDIn ? (VPC - 32'd4) : VPC) & ~32'd3;

    always_ff @(posedge clk) begin
        if (reset) begin
            im       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip       <= '0;
            exc_code <= '0;
            epc_q    <= '0;
        end else begin
            ip <= HWInt;
            if (ExcHandle) begin
                exl      <= 1'b1;
                bd       <= BDIn;
                exc_code <= int_req ? EXC_INT : ExcCodeIn;
                epc_q    <= victim;
            end else begin
                if (WE && A2 == REG_SR) begin
                    im  <= DIn[IM_HI:IM_LO];
                    exl <= DIn[EXL_BIT];
                    ie  <= DIn[IE_BIT];
                end
                if (WE && A2 == REG_EPC)
                    epc_q <= DIn & ~32'd3;
                // eret wins over a same-cycle SR write of EXL.
                if (EXLClr)
                    exl <= 1'b0;
            end
        end
    end

    assign sr_word    = {16'b0, im, 8'b0, exl, ie};
    assign cause_word = {bd, 15'b0, ip, 3'b0, exc_code, 2'b0};
    assign EPC        = epc_q;

    always_comb begin
        DOut = 32'h0;
        case (A1)
            REG_SR:    DOut = sr_word;
            REG_CAUSE: DOut = cause_word;
            REG_EPC:   DOut = epc_q;
            REG_PRID:  DOut = PRID;
            default:   DOut = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_cp0.sv
// Self-checking bench for cp0: directed scenarios plus randomized traffic
// against a word-level register model.
module tb_cp0;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  A1, A2;
    logic [31:0] DIn;
    logic        WE;
    logic [31:0] VPC;
    logic        BDIn;
    logic        ExcOccurIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        ExcHandle;
    logic [31:0] EPC;
    logic [31:0] DOut;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_sr, m_cause, m_epc;

    cp0 dut (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE),
        .VPC(VPC), .BDIn(BDIn), .ExcOccurIn(ExcOccurIn), .ExcCodeIn(ExcCodeIn),
        .HWInt(HWInt), .EXLClr(EXLClr), .ExcHandle(ExcHandle), .EPC(EPC), .DOut(DOut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return 32'h0000_0810;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic m_int();
        return m_sr[0] && !m_sr[1] && ((HWInt & m_sr[15:10]) != 6'd0);
    endfunction

    function automatic logic m_eh();
        return !reset && (m_int() || (ExcOccurIn && !m_sr[1]));
    endfunction

    // Compare combinational outputs against the model for the current inputs.
    task automatic settle_check(input string tag);
        #1;
        chk({tag, "_eh"},   {31'b0, ExcHandle}, {31'b0, m_eh()});
        chk({tag, "_epc"},  EPC, m_epc);
        chk({tag, "_dout"}, DOut, m_read(A1));
    endtask

    // Advance one clock, updating the model from the pre-edge inputs.
    task automatic clk_edge();
        logic [31:0] n_sr, n_cause, n_epc;
        logic [31:0] v;
        n_sr = m_sr; n_cause = m_cause; n_epc = m_epc;
        if (reset) begin
            n_sr = 0; n_cause = 0; n_epc = 0;
        end else begin
            n_cause[15:10] = HWInt;
            if (m_eh()) begin
                n_sr[1]       = 1'b1;
                n_cause[31]   = BDIn;
                n_cause[6:2]  = m_int() ? 5'd0 : ExcCodeIn;
                v             = BDIn ? VPC - 32'd4 : VPC;
                n_epc         = {v[31:2], 2'b00};
            end else begin
                if (WE && A2 == 5'd12) n_sr = DIn & 32'h0000_FC03;
                if (WE && A2 == 5'd14) n_epc = {DIn[31:2], 2'b00};
                if (EXLClr) n_sr[1] = 1'b0;
            end
        end
        @(posedge clk);
        m_sr = n_sr; m_cause = n_cause; m_epc = n_epc;
        #1;
    endtask

    task automatic peek(input string tag, input logic [4:0] a, input logic [31:0] exp);
        A1 = a;
        #1;
        chk(tag, DOut, exp);
    endtask

    task automatic idle();
        reset = 0; WE = 0; A2 = 0; DIn = 0; VPC = 0; BDIn = 0;
        ExcOccurIn = 0; ExcCodeIn = 0; HWInt = 0; EXLClr = 0;
    endtask

    initial begin
        idle();
        A1 = 0;
        m_sr = 0; m_cause = 0; m_epc = 0;
        reset = 1; ExcOccurIn = 1; HWInt = 6'h3F;
        @(posedge clk); #1;
        settle_check("rst");
        chk("rst_eh0", {31'b0, ExcHandle}, 32'd0);
        clk_edge();
        idle();

        peek("rd_sr", 5'd12, 32'h0);
        peek("rd_cause", 5'd13, 32'h0);
        peek("rd_epc", 5'd14, 32'h0);
        peek("rd_prid", 5'd15, 32'h0000_0810);
        peek("rd_unimp", 5'd7, 32'h0);

        WE = 1; A2 = 12; DIn = 32'hFFFF_FFFF; settle_check("mtc0_sr"); clk_edge();
        WE = 1; A2 = 13; settle_check("mtc0_cause"); clk_edge();
        idle();
        peek("sr_mask", 5'd12, 32'h0000_FC03);
        peek("cause_ro", 5'd13, 32'h0);
        WE = 1; A2 = 12; DIn = 0; clk_edge(); idle();

        // AdEL, not in delay slot
        ExcOccurIn = 1; ExcCodeIn = 5'd4; VPC = 32'h0000_3006;
        #1; chk("adel_eh", {31'b0, ExcHandle}, 32'd1);
        clk_edge();
        peek("adel_epc", 5'd14, 32'h0000_3004);
        peek("adel_cause", 5'd13, 32'h0000_0010);
        peek("adel_exl", 5'd12, 32'h0000_0002);
        #1; chk("nested_eh", {31'b0, ExcHandle}, 32'd0);
        clk_edge(); idle();

        EXLClr = 1; clk_edge(); idle();
        WE = 1; A2 = 12; DIn = 32'h0000_0401; clk_edge(); idle();

        // Interrupt beats a simultaneous Ov in a delay slot
        HWInt = 6'b000001; ExcOccurIn = 1; ExcCodeIn = 5'd12; BDIn = 1; VPC = 32'h0000_3010;
        #1; chk("int_eh", {31'b0, ExcHandle}, 32'd1);
        clk_edge();
        ExcOccurIn = 0; BDIn = 0;
        peek("int_epc", 5'd14, 32'h0000_300C);
        peek("int_cause", 5'd13, 32'h8000_0400);

        // eret with same-cycle SR write; pending interrupt fires next cycle
        EXLClr = 1; WE = 1; A2 = 12; DIn = 32'h0000_0403;
        #1; chk("eret_eh", {31'b0, ExcHandle}, 32'd0);
        clk_edge();
        EXLClr = 0; WE = 0;
        peek("eret_sr", 5'd12, 32'h0000_0401);
        chk("pend_eh", {31'b0, ExcHandle}, 32'd1);
        clk_edge(); idle();

        EXLClr = 1; clk_edge(); idle();
        WE = 1; A2 = 14; DIn = 32'h0000_3000; ExcOccurIn = 1; ExcCodeIn = 5'd10; VPC = 32'h0000_3020;
        settle_check("mtc0_vs_exc"); clk_edge(); idle();
        peek("epc_discard", 5'd14, 32'h0000_3020);

        EXLClr = 1; clk_edge(); idle();
        ExcOccurIn = 1; ExcCodeIn = 5'd5; BDIn = 1; VPC = 32'h0;
        settle_check("wrap"); clk_edge(); idle();
        peek("epc_wrap", 5'd14, 32'hFFFF_FFFC);

        for (int i = 0; i < 600; i++) begin
            int sel;
            reset      = ($urandom % 64) == 0;
            WE         = ($urandom % 3) == 0;
            sel        = $urandom % 6;
            A2         = (sel < 4) ? 5'(12 + sel) : 5'($urandom % 32);
            DIn        = $urandom;
            A1         = (($urandom % 4) == 0) ? 5'($urandom % 32) : 5'(12 + $urandom % 4);
            VPC        = (($urandom % 16) == 0) ? 32'h0 : $urandom;
            BDIn       = 1'($urandom % 2);
            ExcOccurIn = ($urandom % 4) == 0;
            ExcCodeIn  = 5'($urandom % 32);
            HWInt      = (($urandom % 3) == 0) ? 6'($urandom % 64) : 6'd0;
            EXLClr     = ($urandom % 6) == 0;
            settle_check("rnd");
            clk_edge();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cp0.md
Name: cp0

Overview:
- Coprocessor 0 for the pipelined MIPS core.
- Receives the exception requests raised by the fetch-side program counter and the later stages, plus external hardware interrupts.
- Decides whether to take the exception, records EPC/Cause/BD, and returns ExcHandle and EPC to the program counter.
- Sits in the M stage: mfc0/mtc0/eret commit here, and the victim PC arrives with the M-stage instruction.

Parameters:
- PRID, 32'h0000_0810, read-only processor ID value returned for register 15.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- A1  input  5  mfc0 read register number
- A2  input  5  mtc0 write register number
- DIn  input  32  mtc0 write data
- WE  input  1  mtc0 write enable (M stage)
- VPC  input  32  PC of the M-stage instruction (victim PC)
- BDIn  input  1  M-stage instruction sits in a branch delay slot
- ExcOccurIn  input  1  pipelined exception flag (fetch AdEL, RI, Ov, AdES, ...)
- ExcCodeIn  input  5  code matching ExcOccurIn
- HWInt  input  6  external interrupt lines, level-sensitive
- EXLClr  input  1  eret committing in M stage
- ExcHandle  output  1  take exception/interrupt this cycle; PC redirects to handler
- EPC  output  32  current EPC register, used by PC on eret
- DOut  output  32  mfc0 read data

Behaviour:
- Registers:
  - SR (12): IM[15:10], EXL[1], IE[0]; other bits read 0.
  - Cause (13): BD[31], IP[15:10], ExcCode[6:2]; other bits 0.
  - EPC (14): 32 bits, [1:0] always 0.
  - PRId (15): constant PRID.
- Reset values: SR=0, Cause=0, EPC=0. ExcHandle=0 during reset regardless of inputs.
- Combinational request logic:
  - IntReq = IE & ~EXL & |(HWInt & IM)
  - ExcReq = ExcOccurIn & ~EXL
  - ExcHandle = IntReq | ExcReq, asserted in the same cycle as the request (0-cycle latency).
- Priority: interrupt over exception. When both are present, ExcCode <= 0 (Int), not ExcCodeIn.
- On a clock edge with ExcHandle=1:
  - EXL <= 1
  - Cause.BD <= BDIn
  - Cause.ExcCode <= IntReq ? 5'd0 : ExcCodeIn
  - EPC <= (BDIn ? VPC-4 : VPC) with bits [1:0] cleared
  - Any simultaneous mtc0 is discarded.
- Cause.IP[15:10] <= HWInt on every non-reset edge, including during EXL.
- mtc0 (WE=1, ExcHandle=0):
  - A2=12 writes only bits 15:10, 1, 0.
  - A2=14 writes EPC with [1:0] forced to 0.
  - A2=13, A2=15 and unimplemented numbers: write ignored.
- eret (EXLClr=1, ExcHandle=0): EXL <= 0 on the edge. If WE to SR occurs in the same cycle, apply the write first, then force EXL=0.
- While EXL=1, further exceptions and interrupts are masked. ExcHandle stays 0 even with ExcOccurIn=1; the nested request is dropped, not queued.
- mfc0: DOut = register selected by A1, combinational. Unimplemented numbers read 32'h0. A same-cycle mtc0 is not forwarded; the new value is visible the next cycle.
- Arithmetic: VPC-4 is 32-bit wrap-around (VPC=0 gives 32'hFFFF_FFFC).
- Reset asserted mid-handler clears EXL; the pipeline restarts from PC INIT.

Decomposition:
- Shared macro.vh holds:
  - CP0 register numbers (SR=12, CAUSE=13, EPC=14, PRID=15)
  - field bit positions (IM, EXL, IE, BD, IP, ExcCode)
  - exception codes: EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_RI=10, EXC_OV=12
  - EXCEPTION_HANDLER_ADDR = 32'h0000_4180
- No sub-module: a single flat module with one register per CP0 register.

Test Plan:
- Reset, then mfc0 12/13/14/15 -> 0, 0, 0, 32'h0000_0810; mfc0 7 -> 0.
- mtc0 SR=32'hFFFF_FFFF, then read -> 32'h0000_FC03. mtc0 Cause=32'hFFFF_FFFF -> Cause unchanged.
- ExcOccurIn=1, ExcCodeIn=4 (AdEL), VPC=32'h0000_3006, BDIn=0 ->
  - ExcHandle=1 same cycle
  - next cycle: EPC=32'h0000_3004, ExcCode=4, EXL=1
  - repeat request while EXL=1 -> ExcHandle=0.
- SR=32'h0000_0401, HWInt=6'b000001, ExcOccurIn=1 code 12, BDIn=1, VPC=32'h0000_3010 ->
  - ExcHandle=1
  - EPC=32'h0000_300C, BD=1, ExcCode=0, IP[10]=1.
- EXL=1, EXLClr=1 with mtc0 SR=32'h0000_0403 same cycle -> SR reads 32'h0000_0401, and a pending enabled interrupt raises ExcHandle the following cycle.
- mtc0 EPC=32'h0000_3000 together with ExcOccurIn=1, VPC=32'h0000_3020 -> EPC=32'h0000_3020 (write discarded).
